plic_lite: RTL and testbench
============================

PLIC_LITE -- requirements
Module: plic_lite

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 7: number of interrupt sources, IDs 1..NUM_SOURCES, legal range 1..31.
REQ-002 SHALL have parameter PRIORITY_WIDTH, default 3: width of the per-source priority and threshold fields.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wb_cyc  in  1  bus cycle valid.
REQ-006 wb_stb  in  1  bus strobe.
REQ-007 wb_we  in  1  1 = write, 0 = read.
REQ-008 wb_addr  in  22  byte address; bits [1:0] ignored.
REQ-009 wb_dat_i  in  32  write data.
REQ-010 wb_dat_o  out  32  read data, valid while wb_ack = 1.
REQ-011 wb_ack  out  1  single-cycle acknowledge.
REQ-012 interrupt_sources  in  NUM_SOURCES  level-triggered, asynchronous sources; bit i-1 is source ID i.
REQ-013 external_interrupt  out  1  M-mode external interrupt request to the hart CSR unit.

Function
REQ-014 Register map, applied per access:
- 0x000000+4*i: priority[i] (R/W), i = 1..NUM_SOURCES; ID 0 reads 0 and ignores writes.
- 0x001000: pending (RO); bit i = pending[i].
- 0x002000: enable (R/W); bit i enables ID i.
- 0x200000: threshold (R/W).
- 0x200004: claim on read, complete on write.
REQ-015 Field widths:
- Unimplemented bits read 0 and ignore writes; this covers priority/threshold bits at or above PRIORITY_WIDTH, enable bit 0, and enable bits above NUM_SOURCES.
- Unmapped addresses read 0 and ignore writes; they are still acknowledged.
REQ-016 Bus FSM has two states, IDLE and ACK:
- IDLE -> ACK when wb_cyc & wb_stb; the access takes effect on that edge and wb_dat_o is registered.
- ACK -> IDLE unconditionally.
- wb_ack = 1 only in ACK, so each access acknowledges exactly one cycle after it is sampled.
- No new access is sampled while in ACK.
REQ-017 Each source passes through a 2-flop synchronizer (sync[i]).
REQ-018 Gateway: pending[i] is set on the edge where sync[i] & !pending[i] & !in_flight[i].
REQ-019 A claim read returns the ID with pending & enable & priority > threshold and the highest priority; ties go to the lowest ID.
REQ-020 A claim read with a returned ID ≠ 0 clears pending[ID] and sets in_flight[ID] on the access edge.
REQ-021 A claim read with no eligible ID returns 0 and changes no state.
REQ-022 A complete write with wb_dat_i[4:0] = ID, 1 ≤ ID ≤ NUM_SOURCES, clears in_flight[ID]; other values are ignored.
- Completion is accepted even if the ID is not enabled.
REQ-023 external_interrupt is registered: it equals the OR over i of (pending[i] & enable[i] & priority[i] > threshold), evaluated on the previous cycle's state.
REQ-024 Simultaneous events:
- A claim of ID i and the gateway set of i on the same edge: the claim wins; pending[i] ends 0 and in_flight[i] ends 1.
- A complete of i with sync[i] still high: in_flight[i] clears, and pending[i] sets on the following edge.
REQ-025 Priority 0 never interrupts and is never claimed.
REQ-026 Source-to-output latency: a source that rises before edge 1, with enable set and priority > threshold, yields pending on edge 3 and external_interrupt on edge 4.

Reset
REQ-027 Reset clears all state asynchronously:
- priority, enable and threshold become 0.
- pending, in_flight and both synchronizer stages become 0.
- Bus FSM returns to IDLE.
- wb_ack = 0, wb_dat_o = 0, external_interrupt = 0.
REQ-028 Reset asserted mid-access aborts the access: no ack and no register update.

Verification
REQ-029 Enable ID 3 with priority 2 and threshold 0, raise source 3 -> pending = 0x8 after 3 edges; external_interrupt = 1 on the 4th edge.
REQ-030 IDs 2 and 5, both priority 4, pending and enabled; claim -> 2, then claim -> 5, then claim -> 0; external_interrupt falls 1 cycle after the second claim.
REQ-031 ID 1 pending with priority 3 and threshold 3 -> external_interrupt = 0 and claim returns 0; set threshold to 2 -> external_interrupt = 1 one cycle after the write is acknowledged.
REQ-032 Claim ID 4, keep source 4 high -> pending[4] stays 0 until complete(4); pending[4] = 1 on the edge after the complete.
REQ-033 Bus checks:
- Write 0xFFFFFFFF to 0x000008 -> reads back 0x7.
- Write to 0x001000 -> pending unchanged.
- Read 0x3FFFFC -> 0, acknowledged in 1 cycle.
REQ-034 Assert reset during ACK with enable = 0xFE -> wb_ack = 0 and enable reads 0 afterwards.

Source files
------------

// File: rtl/plic_lite.sv
`default_nettype none
// ============================================================================
// plic_lite : compact platform-level interrupt controller with a Wishbone
//             register port, a level-triggered gateway per source and claim/complete.
// Revision  : 1.0
// ============================================================================
module plic_lite #(
   parameter int NUM_SOURCES    = 7,
   parameter int PRIORITY_WIDTH = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wb_cyc,
   input  logic                   wb_stb,
   input  logic                   wb_we,
   input  logic [21:0]            wb_addr,
   input  logic [31:0]            wb_dat_i,
   output logic [31:0]            wb_dat_o,
   output logic                   wb_ack,
   input  logic [NUM_SOURCES-1:0] interrupt_sources,
   output logic                   external_interrupt
);

   localparam int N  = NUM_SOURCES;
   localparam int PW = PRIORITY_WIDTH;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACK  = 1'b1;

   localparam logic [19:0] PENDING_W = 20'h00400;
   localparam logic [19:0] ENABLE_W  = 20'h00800;
   localparam logic [19:0] THRESH_W  = 20'h80000;
   localparam logic [19:0] CLAIM_W   = 20'h80001;

   logic [0:0]    state_q, state_d;
   logic [31:0]   dat_o_q, dat_o_d;
   logic [N:1]    sync1_q, sync2_q;
   logic [N:1]    pending_q, pending_d;
   logic [N:1]    in_flight_q, in_flight_d;
   logic [N:1]    enable_q, enable_d;
   logic [PW-1:0] threshold_q, threshold_d;
   logic [PW-1:0] prio_q [1:N];
   logic [PW-1:0] prio_d [1:N];
   logic          ext_q, ext_d;

   logic          access;
   logic [19:0]   word;
   logic [N:1]    eligible;
   logic [4:0]    claim_id;
   logic [PW-1:0] best_prio;
   logic          unused_bits;

   assign word        = wb_addr[21:2];
   assign access      = (state_q == IDLE) && wb_cyc && wb_stb;
   assign unused_bits = ^{wb_addr[1:0], wb_dat_i};

   // Strict '>' while scanning upward keeps the lowest ID on priority ties.
   always_comb begin
      eligible  = '0;
      claim_id  = 5'd0;
      best_prio = '0;
      for (int i = 1; i <= N; i++) begin
         eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
         if (eligible[i] && (prio_q[i] > best_prio)) begin
            claim_id  = 5'(i);
            best_prio = prio_q[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      dat_o_d     = dat_o_q;
      pending_d   = pending_q;
      in_flight_d = in_flight_q;
      enable_d    = enable_q;
      threshold_d = threshold_q;
      prio_d      = prio_q;
      ext_d       = |eligible;

      for (int i = 1; i <= N; i++) begin
         if (sync2_q[i] && !pending_q[i] && !in_flight_q[i]) pending_d[i] = 1'b1;
      end

      if (state_q == ACK) state_d = IDLE;

      if (access) begin
         state_d = ACK;
         dat_o_d = '0;
         for (int i = 1; i <= N; i++) begin
            if (word == 20'(i)) begin
               dat_o_d[PW-1:0] = prio_q[i];
               if (wb_we) prio_d[i] = wb_dat_i[PW-1:0];
            end
         end
         case (word)
            PENDING_W: begin
               for (int i = 1; i <= N; i++) dat_o_d[i] = pending_q[i];
            end
            ENABLE_W: begin
               for (int i = 1; i <= N; i++) dat_o_d[i] = enable_q[i];
               if (wb_we) enable_d = wb_dat_i[N:1];
            end
            THRESH_W: begin
               dat_o_d[PW-1:0] = threshold_q;
               if (wb_we) threshold_d = wb_dat_i[PW-1:0];
            end
            CLAIM_W: begin
               if (wb_we) begin
                  for (int i = 1; i <= N; i++) begin
                     if (wb_dat_i[4:0] == 5'(i)) in_flight_d[i] = 1'b0;
                  end
               end else begin
                  // Claim overrides a gateway set of the same ID on this edge.
                  dat_o_d = {27'd0, claim_id};
                  for (int i = 1; i <= N; i++) begin
                     if (claim_id == 5'(i)) begin
                        pending_d[i]   = 1'b0;
                        in_flight_d[i] = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         dat_o_q     <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         pending_q   <= '0;
         in_flight_q <= '0;
         enable_q    <= '0;
         threshold_q <= '0;
         ext_q       <= 1'b0;
         for (int i = 1; i <= N; i++) prio_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         dat_o_q     <= dat_o_d;
         sync1_q     <= interrupt_sources;
         sync2_q     <= sync1_q;
         pending_q   <= pending_d;
         in_flight_q <= in_flight_d;
         enable_q    <= enable_d;
         threshold_q <= threshold_d;
         ext_q       <= ext_d;
         for (int i = 1; i <= N; i++) prio_q[i] <= prio_d[i];
      end
   end

   assign wb_ack             = (state_q == ACK);
   assign wb_dat_o           = dat_o_q;
   assign external_interrupt = ext_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_lite.sv
`default_nettype none
// ============================================================================
// tb_plic_lite : directed self-checking bench for plic_lite with a read scoreboard.
// Revision     : 1.0
// ============================================================================
module tb_plic_lite;

   localparam logic [21:0] PEND = 22'h001000;
   localparam logic [21:0] EN   = 22'h002000;
   localparam logic [21:0] TH   = 22'h200000;
   localparam logic [21:0] CLM  = 22'h200004;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [21:0] wb_addr = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack;
   logic [6:0]  src = '0;
   logic        external_interrupt;

   int          checks = 0;
   int          errors = 0;
   logic        ext_at_ack;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   plic_lite #(.NUM_SOURCES(7), .PRIORITY_WIDTH(3)) dut (
      .clock              (clock),
      .reset              (reset),
      .wb_cyc             (wb_cyc),
      .wb_stb             (wb_stb),
      .wb_we              (wb_we),
      .wb_addr            (wb_addr),
      .wb_dat_i           (wb_dat_i),
      .wb_dat_o           (wb_dat_o),
      .wb_ack             (wb_ack),
      .interrupt_sources  (src),
      .external_interrupt (external_interrupt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Access is sampled on the first edge, acked in the following cycle,
   // and the task returns once the FSM is back in IDLE.
   task automatic bus(input logic we, input logic [21:0] a, input logic [31:0] d,
                      output logic [31:0] r);
      int n;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_dat_i = d;
      @(posedge clock); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      n = 0;
      while (!wb_ack && n < 4) begin
         @(posedge clock); #1;
         n++;
      end
      chk("ack_latency", 32'(n), 32'd0);
      ext_at_ack = external_interrupt;
      r = wb_dat_o;
      tick(1);
   endtask

   task automatic wr(input logic [21:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic rd(input logic [21:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] r;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      bus(1'b0, a, 32'd0, r);
      chk(tag_q.pop_front(), r, exp_q.pop_front());
   endtask

   initial begin
      tick(2);
      chk("reset_ack", 32'(wb_ack), 32'd0);
      chk("reset_dat", wb_dat_o, 32'd0);
      chk("reset_ext", 32'(external_interrupt), 32'd0);
      reset = 1'b0;
      tick(1);
      rd(PEND, 32'h0, "reset_pending");
      rd(EN, 32'h0, "reset_enable");
      rd(TH, 32'h0, "reset_threshold");
      rd(22'h00000C, 32'h0, "reset_prio3");

      // Source-to-interrupt latency on ID 3
      wr(22'h00000C, 32'd2);
      wr(EN, 32'h8);
      wr(TH, 32'd0);
      src[2] = 1'b1;
      rd(PEND, 32'h0, "lat_pend_edge1");
      chk("lat_ext_edge2", 32'(external_interrupt), 32'd0);
      rd(PEND, 32'h0, "lat_pend_edge3");
      chk("lat_ext_edge3", 32'(ext_at_ack), 32'd0);
      chk("lat_ext_edge4", 32'(external_interrupt), 32'd1);
      rd(PEND, 32'h8, "lat_pend_set");
      src[2] = 1'b0;
      tick(3);
      rd(CLM, 32'd3, "claim_id3");
      wr(CLM, 32'd3);
      rd(PEND, 32'h0, "pend_after_complete3");
      chk("ext_idle", 32'(external_interrupt), 32'd0);

      // Priority tie between IDs 2 and 5
      wr(22'h000008, 32'd4);
      wr(22'h000014, 32'd4);
      wr(EN, 32'h24);
      src[1] = 1'b1; src[4] = 1'b1;
      tick(4);
      src[1] = 1'b0; src[4] = 1'b0;
      tick(3);
      rd(PEND, 32'h24, "tie_pending");
      rd(CLM, 32'd2, "tie_claim2");
      chk("tie_ext_after1", 32'(external_interrupt), 32'd1);
      rd(CLM, 32'd5, "tie_claim5");
      chk("tie_ext_at_ack", 32'(ext_at_ack), 32'd1);
      chk("tie_ext_falls", 32'(external_interrupt), 32'd0);
      rd(CLM, 32'd0, "tie_claim_none");
      wr(CLM, 32'd2);
      wr(CLM, 32'd5);

      // Threshold masking on ID 1
      wr(22'h000004, 32'd3);
      wr(TH, 32'd3);
      wr(EN, 32'h26);
      src[0] = 1'b1;
      tick(4);
      src[0] = 1'b0;
      tick(3);
      chk("thr_ext_masked", 32'(external_interrupt), 32'd0);
      rd(CLM, 32'd0, "thr_claim_masked");
      rd(PEND, 32'h2, "thr_pend_kept");
      wr(TH, 32'd2);
      chk("thr_ext_at_ack", 32'(ext_at_ack), 32'd0);
      chk("thr_ext_after", 32'(external_interrupt), 32'd1);
      rd(CLM, 32'd1, "thr_claim1");
      wr(CLM, 32'd1);

      // Gateway blocked while ID 4 is in flight
      wr(22'h000010, 32'd5);
      wr(EN, 32'h36);
      src[3] = 1'b1;
      tick(4);
      rd(CLM, 32'd4, "flight_claim4");
      rd(PEND, 32'h0, "flight_pend_blocked");
      tick(5);
      rd(PEND, 32'h0, "flight_pend_still");
      wr(CLM, 32'd4);
      chk("flight_ext_at_ack", 32'(ext_at_ack), 32'd0);
      chk("flight_ext_edge1", 32'(external_interrupt), 32'd0);
      tick(1);
      chk("flight_ext_edge2", 32'(external_interrupt), 32'd1);
      rd(PEND, 32'h10, "flight_repend");
      src[3] = 1'b0;
      tick(3);
      rd(CLM, 32'd4, "flight_reclaim4");
      wr(CLM, 32'd4);
      wr(CLM, 32'd9);
      rd(CLM, 32'd0, "claim_empty");

      // Field widths and unmapped space
      wr(22'h000008, 32'hFFFF_FFFF);
      rd(22'h000008, 32'h7, "prio2_width");
      wr(22'h000000, 32'hFFFF_FFFF);
      rd(22'h000000, 32'h0, "prio0_zero");
      wr(PEND, 32'hFFFF_FFFF);
      rd(PEND, 32'h0, "pending_ro");
      rd(22'h3FFFFC, 32'h0, "unmapped_read");
      wr(EN, 32'hFFFF_FFFF);
      rd(EN, 32'hFE, "enable_width");
      wr(TH, 32'hFFFF_FFFF);
      rd(TH, 32'h7, "thr_width");

      // Reset during ACK
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = EN;
      @(posedge clock); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      chk("pre_reset_ack", 32'(wb_ack), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_ack_cleared", 32'(wb_ack), 32'd0);
      chk("rst_dat_cleared", wb_dat_o, 32'd0);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = EN; wb_dat_i = 32'h2;
      tick(1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      reset = 1'b0;
      tick(1);
      rd(EN, 32'h0, "rst_enable_zero");
      rd(TH, 32'h0, "rst_thr_zero");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
